// File: rtl/mcb_ref_timer_pkg.sv
// Shared MCB refresh-timer constants: parameter defaults, widths and the
// counter-width helper used by the timer and its interval ticker.
package mcb_ref_timer_pkg;

    localparam int MCB_TREFI_CK_DEF  = 780;
    localparam int MCB_REF_MAX_DEF   = 8;
    localparam int MCB_REF_ALERT_DEF = 6;
    localparam int MCB_PEND_W        = 4;

    // Width of a down-counter that must hold ticks-1; never narrower than one bit.
    function automatic int cnt_width(input int ticks);
        return (ticks < 2) ? 1 : $clog2(ticks);
    endfunction

    localparam int MCB_REF_CNT_W_DEF = cnt_width(MCB_TREFI_CK_DEF);

endpackage

// File: rtl/mcb_ref_timer_if.sv
// Command-controller <-> refresh-timer signal bundle.
interface mcb_ref_timer_if;
    import mcb_ref_timer_pkg::*;

    logic                  i_ready;
    logic                  c_ref;
    logic                  r_ref_req;
    logic                  r_ref_alert;
    logic [MCB_PEND_W-1:0] r_ref_pend;
    logic                  r_ref_ovf;
    logic                  r_ref_err;

    modport master (
        output i_ready, c_ref,
        input  r_ref_req, r_ref_alert, r_ref_pend, r_ref_ovf, r_ref_err
    );

    modport slave (
        input  i_ready, c_ref,
        output r_ref_req, r_ref_alert, r_ref_pend, r_ref_ovf, r_ref_err
    );

endinterface

// File: rtl/mcb_ref_tick.sv
// Refresh-interval down-counter: reloads while idle, emits a one-cycle tick
// on the cycle it sits at zero while running.
module mcb_ref_tick
    import mcb_ref_timer_pkg::*;
#(
    parameter int TICKS = MCB_TREFI_CK_DEF,
    parameter int CNT_W = cnt_width(TICKS)
) (
    input  logic mcb_clk,
    input  logic mcb_rst_n,
    input  logic mcb_sclr_n,
    input  logic run,
    output logic tick
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TICKS - 1);
    localparam logic [CNT_W-1:0] ZERO   = {CNT_W{1'b0}};

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // Next count: hold at reload unless running, wrap to reload at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (!mcb_sclr_n) begin
            cnt_d = RELOAD;
        end else if (!run) begin
            cnt_d = RELOAD;
        end else if (cnt_q == ZERO) begin
            cnt_d = RELOAD;
        end else begin
            cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Interval counter register.
    always_ff @(posedge mcb_clk or negedge mcb_rst_n) begin
        if (!mcb_rst_n) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = run && (cnt_q == ZERO);

endmodule

// File: rtl/mcb_ref_timer.sv
// SDRAM refresh timer: counts refresh intervals, tracks postponed refreshes
// and flags lost ticks and spurious refresh commands.
module mcb_ref_timer
    import mcb_ref_timer_pkg::*;
#(
    parameter int MCB_tREFI_CK  = MCB_TREFI_CK_DEF,
    parameter int MCB_REF_MAX   = MCB_REF_MAX_DEF,
    parameter int MCB_REF_ALERT = MCB_REF_ALERT_DEF
) (
    input  logic            mcb_clk,
    input  logic            mcb_rst_n,
    input  logic            mcb_sclr_n,
    mcb_ref_timer_if.slave  bus
);

    typedef enum logic [0:0] {
        WAIT_INIT = 1'b0,
        RUN       = 1'b1
    } state_e;

    localparam logic [MCB_PEND_W-1:0] PEND_MAX   = MCB_PEND_W'(MCB_REF_MAX);
    localparam logic [MCB_PEND_W-1:0] PEND_ALERT = MCB_PEND_W'(MCB_REF_ALERT);
    localparam logic [MCB_PEND_W-1:0] PEND_ZERO  = {MCB_PEND_W{1'b0}};
    localparam logic [MCB_PEND_W-1:0] PEND_ONE   = {{(MCB_PEND_W-1){1'b0}}, 1'b1};

    state_e                state_d, state_q;
    logic [MCB_PEND_W-1:0] pend_d,  pend_q;
    logic                  ovf_d,   ovf_q;
    logic                  err_d,   err_q;
    logic                  req_d,   req_q;
    logic                  alert_d, alert_q;
    logic                  run;
    logic                  tick;

    assign run = (state_q == RUN) && bus.i_ready;

    mcb_ref_tick #(
        .TICKS (MCB_tREFI_CK)
    ) u_tick (
        .mcb_clk    (mcb_clk),
        .mcb_rst_n  (mcb_rst_n),
        .mcb_sclr_n (mcb_sclr_n),
        .run        (run),
        .tick       (tick)
    );

    // Next state, pending count and sticky flags; sync clear wins over everything.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        if (!mcb_sclr_n) begin
            state_d = WAIT_INIT;
            pend_d  = PEND_ZERO;
            ovf_d   = 1'b0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                WAIT_INIT: begin
                    pend_d = PEND_ZERO;
                    if (bus.i_ready) begin
                        state_d = RUN;
                    end else begin
                        state_d = WAIT_INIT;
                    end
                end
                RUN: begin
                    if (!bus.i_ready) begin
                        state_d = WAIT_INIT;
                        pend_d  = PEND_ZERO;
                    end else begin
                        // Coincident tick and refresh cancel out, even at the limits.
                        case ({tick, bus.c_ref})
                            2'b10: begin
                                if (pend_q == PEND_MAX) begin
                                    ovf_d = 1'b1;
                                end else begin
                                    pend_d = pend_q + PEND_ONE;
                                end
                            end
                            2'b01: begin
                                if (pend_q == PEND_ZERO) begin
                                    err_d = 1'b1;
                                end else begin
                                    pend_d = pend_q - PEND_ONE;
                                end
                            end
                            default: begin
                                pend_d = pend_q;
                            end
                        endcase
                    end
                end
                default: begin
                    state_d = WAIT_INIT;
                    pend_d  = PEND_ZERO;
                end
            endcase
        end
        req_d   = (pend_d != PEND_ZERO);
        alert_d = (pend_d >= PEND_ALERT);
    end

    // State, pending count and output registers.
    always_ff @(posedge mcb_clk or negedge mcb_rst_n) begin
        if (!mcb_rst_n) begin
            state_q <= WAIT_INIT;
            pend_q  <= PEND_ZERO;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            alert_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            req_q   <= req_d;
            alert_q <= alert_d;
        end
    end

    assign bus.r_ref_req   = req_q;
    assign bus.r_ref_alert = alert_q;
    assign bus.r_ref_pend  = pend_q;
    assign bus.r_ref_ovf   = ovf_q;
    assign bus.r_ref_err   = err_q;

endmodule

// File: tb/tb_mcb_ref_timer.sv
// Self-checking bench for mcb_ref_timer: a cycle model pushes expected outputs
// into a scoreboard queue, each scenario task pops and compares after the edge.
module tb_mcb_ref_timer;

    localparam int T     = 16;
    localparam int MAXP  = 8;
    localparam int ALERT = 6;

    logic mcb_clk;
    logic mcb_rst_n;
    logic mcb_sclr_n;

    mcb_ref_timer_if bus ();

    mcb_ref_timer #(
        .MCB_tREFI_CK  (T),
        .MCB_REF_MAX   (MAXP),
        .MCB_REF_ALERT (ALERT)
    ) dut (
        .mcb_clk    (mcb_clk),
        .mcb_rst_n  (mcb_rst_n),
        .mcb_sclr_n (mcb_sclr_n),
        .bus        (bus)
    );

    initial mcb_clk = 1'b0;
    always #5 mcb_clk = ~mcb_clk;

    int checks = 0;
    int errors = 0;

    // Outputs packed as {req, alert, pend[3:0], ovf, err}.
    logic [7:0] obs;
    assign obs = {bus.r_ref_req, bus.r_ref_alert, bus.r_ref_pend, bus.r_ref_ovf, bus.r_ref_err};

    logic [7:0] sb[$];
    logic [7:0] exp_v;

    bit m_run;
    int m_cnt;
    int m_pend;
    bit m_ovf;
    bit m_err;

    task automatic model_reset();
        m_run  = 1'b0;
        m_cnt  = T - 1;
        m_pend = 0;
        m_ovf  = 1'b0;
        m_err  = 1'b0;
    endtask

    // Drive one cycle of inputs, predict the post-edge outputs, advance past the edge.
    task automatic step(input logic ready, input logic cref, input logic sclr);
        bit tick;
        bus.i_ready = ready;
        bus.c_ref   = cref;
        mcb_sclr_n  = sclr;
        if (!sclr) begin
            model_reset();
        end else if (!m_run) begin
            m_pend = 0;
            m_cnt  = T - 1;
            if (ready) m_run = 1'b1;
        end else if (!ready) begin
            m_run  = 1'b0;
            m_pend = 0;
            m_cnt  = T - 1;
        end else begin
            tick  = (m_cnt == 0);
            m_cnt = tick ? T - 1 : m_cnt - 1;
            if (tick && !cref) begin
                if (m_pend == MAXP) m_ovf = 1'b1;
                else m_pend = m_pend + 1;
            end else if (!tick && cref) begin
                if (m_pend == 0) m_err = 1'b1;
                else m_pend = m_pend - 1;
            end
        end
        sb.push_back({(m_pend != 0), (m_pend >= ALERT), 4'(m_pend), m_ovf, m_err});
        @(posedge mcb_clk);
        #1;
    endtask

    task automatic test_reset();
        mcb_rst_n   = 1'b0;
        mcb_sclr_n  = 1'b1;
        bus.i_ready = 1'b0;
        bus.c_ref   = 1'b0;
        model_reset();
        repeat (3) @(posedge mcb_clk);
        #1;
        checks++;
        if (obs !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs obs=%h exp=%h", obs, 8'h00);
        end
        @(negedge mcb_clk);
        mcb_rst_n = 1'b1;
        // c_ref while waiting for init must be ignored.
        for (int i = 0; i < 4; i++) begin
            step(1'b0, (i % 2 == 0) ? 1'b1 : 1'b0, 1'b1);
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL reset_wait_init cyc=%0d obs=%h exp=%h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_first_tick(input string tag);
        int first;
        first = -1;
        step(1'b1, 1'b0, 1'b1);
        exp_v = sb.pop_front();
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s_enter obs=%h exp=%h", tag, obs, exp_v);
        end
        for (int i = 1; i <= 40 && first < 0; i++) begin
            step(1'b1, 1'b0, 1'b1);
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL %s_cycle cyc=%0d obs=%h exp=%h", tag, i, obs, exp_v);
            end
            if (bus.r_ref_req === 1'b1) begin
                first = i;
                checks++;
                if (bus.r_ref_pend !== 4'd1 || bus.r_ref_alert !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_tick_outputs pend=%0d alert=%b exp pend=1 alert=0",
                             tag, bus.r_ref_pend, bus.r_ref_alert);
                end
            end
        end
        checks++;
        if (first != T) begin
            errors++;
            $display("FAIL %s_latency got=%0d exp=%0d", tag, first, T);
        end
    endtask

    task automatic test_saturation();
        int ovf_at;
        int alert_pend;
        ovf_at     = -1;
        alert_pend = -1;
        for (int i = 1; i <= 200 && ovf_at < 0; i++) begin
            step(1'b1, 1'b0, 1'b1);
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL sat_cycle cyc=%0d obs=%h exp=%h", i, obs, exp_v);
            end
            if (bus.r_ref_alert === 1'b1 && alert_pend < 0) alert_pend = int'(bus.r_ref_pend);
            if (bus.r_ref_ovf === 1'b1) begin
                ovf_at = i;
                checks++;
                if (bus.r_ref_pend !== 4'd8) begin
                    errors++;
                    $display("FAIL sat_ovf_pend got=%0d exp=8", bus.r_ref_pend);
                end
            end
        end
        checks++;
        if (alert_pend != ALERT) begin
            errors++;
            $display("FAIL sat_alert_pend got=%0d exp=%0d", alert_pend, ALERT);
        end
        checks++;
        if (ovf_at != 8 * T) begin
            errors++;
            $display("FAIL sat_ovf_time got=%0d exp=%0d", ovf_at, 8 * T);
        end
    endtask

    task automatic run_until_pend(input int pend, input int cnt, input string tag);
        for (int i = 0; i < 200 && !(m_pend == pend && (cnt < 0 || m_cnt == cnt)); i++) begin
            step(1'b1, 1'b0, 1'b1);
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL %s_run cyc=%0d obs=%h exp=%h", tag, i, obs, exp_v);
            end
        end
        checks++;
        if (m_pend != pend) begin
            errors++;
            $display("FAIL %s_reach model_pend=%0d exp=%0d", tag, m_pend, pend);
        end
    endtask

    task automatic test_cref_on_tick();
        step(1'b1, 1'b0, 1'b0);
        void'(sb.pop_front());
        step(1'b1, 1'b0, 1'b1);
        void'(sb.pop_front());
        run_until_pend(2, 0, "cot");
        step(1'b1, 1'b1, 1'b1);
        exp_v = sb.pop_front();
        checks++;
        if (obs !== exp_v || bus.r_ref_pend !== 4'd2) begin
            errors++;
            $display("FAIL cot_same_cycle obs=%h exp=%h pend=%0d exp_pend=2", obs, exp_v, bus.r_ref_pend);
        end
        step(1'b1, 1'b1, 1'b1);
        exp_v = sb.pop_front();
        checks++;
        if (obs !== exp_v || bus.r_ref_pend !== 4'd1) begin
            errors++;
            $display("FAIL cot_next_cref obs=%h exp=%h pend=%0d exp_pend=1", obs, exp_v, bus.r_ref_pend);
        end
    endtask

    task automatic test_err();
        step(1'b1, 1'b1, 1'b1);
        exp_v = sb.pop_front();
        checks++;
        if (obs !== exp_v || bus.r_ref_pend !== 4'd0) begin
            errors++;
            $display("FAIL err_drain obs=%h exp=%h", obs, exp_v);
        end
        step(1'b1, 1'b1, 1'b1);
        exp_v = sb.pop_front();
        checks++;
        if (obs !== exp_v || bus.r_ref_err !== 1'b1 || bus.r_ref_pend !== 4'd0) begin
            errors++;
            $display("FAIL err_set obs=%h exp=%h err=%b exp_err=1", obs, exp_v, bus.r_ref_err);
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 1'b1);
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v || bus.r_ref_err !== 1'b1) begin
                errors++;
                $display("FAIL err_sticky cyc=%0d obs=%h exp=%h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_ready_drop();
        step(1'b1, 1'b0, 1'b0);
        void'(sb.pop_front());
        step(1'b1, 1'b0, 1'b1);
        void'(sb.pop_front());
        run_until_pend(5, 7, "drop");
        step(1'b0, 1'b0, 1'b1);
        exp_v = sb.pop_front();
        checks++;
        if (obs !== exp_v || bus.r_ref_pend !== 4'd0 || bus.r_ref_req !== 1'b0) begin
            errors++;
            $display("FAIL drop_clear obs=%h exp=%h", obs, exp_v);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b1);
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v || bus.r_ref_err !== 1'b0) begin
                errors++;
                $display("FAIL drop_wait_cref cyc=%0d obs=%h exp=%h", i, obs, exp_v);
            end
        end
        test_first_tick("drop_rearm");
    endtask

    task automatic test_sclr_and_async();
        step(1'b1, 1'b0, 1'b0);
        void'(sb.pop_front());
        step(1'b1, 1'b0, 1'b1);
        void'(sb.pop_front());
        for (int i = 0; i < 200 && !m_ovf; i++) begin
            step(1'b1, 1'b0, 1'b1);
            exp_v = sb.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL sclr_fill cyc=%0d obs=%h exp=%h", i, obs, exp_v);
            end
        end
        step(1'b1, 1'b1, 1'b1);
        exp_v = sb.pop_front();
        checks++;
        if (obs !== exp_v || bus.r_ref_pend !== 4'd7 || bus.r_ref_ovf !== 1'b1) begin
            errors++;
            $display("FAIL sclr_pre obs=%h exp=%h pend=%0d exp_pend=7", obs, exp_v, bus.r_ref_pend);
        end
        step(1'b1, 1'b0, 1'b0);
        exp_v = sb.pop_front();
        checks++;
        if (obs !== 8'h00 || obs !== exp_v) begin
            errors++;
            $display("FAIL sclr_clear obs=%h exp=%h", obs, 8'h00);
        end
        test_first_tick("sclr_rearm");
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b1);
            void'(sb.pop_front());
        end
        #2;
        mcb_rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (obs !== 8'h00) begin
            errors++;
            $display("FAIL async_reset obs=%h exp=%h", obs, 8'h00);
        end
        @(negedge mcb_clk);
        mcb_rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b1);
        exp_v = sb.pop_front();
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL async_after obs=%h exp=%h", obs, exp_v);
        end
    endtask

    initial begin
        test_reset();
        test_first_tick("first");
        test_saturation();
        test_cref_on_tick();
        test_err();
        test_ready_drop();
        test_sclr_and_async();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
